ps2_event_reporter: RTL and testbench

- Sits between PS2Receiver and the UART byte path (uart_tx or a byte FIFO in front of it).
- Takes 16-bit keycode snapshots and their valid pulses, and filters typematic repeats and partial codes.
- Queues accepted make/break events in an internal FIFO and serialises each one as an ASCII hex string with an optional terminator.
- Successor to the fixed 2-byte keyboard-to-UART path: configurable queue depth, filtering modes and terminator, plus a valid/ready output and overflow accounting.

---
 rtl/ps2_pkg.sv | 27 ++
 rtl/ps2_event_fifo.sv | 51 +++++
 rtl/ps2_event_reporter.sv | 160 ++++++++++++++++
 tb/tb_ps2_event_reporter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// Shared constants, entry layout and ASCII helper for the PS/2 event reporter.
// Kind codes here are also the FIFO entry tag.
package ps2_pkg;

    localparam logic [1:0] KIND_MAKE  = 2'd0;
    localparam logic [1:0] KIND_EXT   = 2'd1;
    localparam logic [1:0] KIND_BREAK = 2'd2;

    localparam logic [7:0] PFX_BREAK = 8'hF0;
    localparam logic [7:0] PFX_EXT   = 8'hE0;

    localparam logic [7:0] ASCII_SP = 8'h20;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    localparam int ENTRY_W = 18;

    typedef struct packed {
        logic [1:0]  kind;
        logic [15:0] code;
    } ps2_entry_t;

    function automatic logic [7:0] nib2ascii(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// Show-ahead synchronous FIFO; a push into a full FIFO is taken only
// when a pop happens in the same cycle.
module ps2_event_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 18
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q;
    logic [AW-1:0]    rptr_q;
    logic [AW:0]      cnt_q;
    logic             wr_en;
    logic             rd_en;

    assign full_o  = (cnt_q == FULL_CNT);
    assign empty_o = (cnt_q == '0);
    assign wr_en   = push_i && (!full_o || pop_i);
    assign rd_en   = pop_i && !empty_o;
    assign rdata_o = mem_q[rptr_q];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (wr_en) wptr_q <= wptr_q + 1'b1;
            if (rd_en) rptr_q <= rptr_q + 1'b1;
            cnt_q <= cnt_q + (AW + 1)'(wr_en) - (AW + 1)'(rd_en);
        end
    end

endmodule

// File: rtl/ps2_event_reporter.sv
// Filters PS/2 keycode snapshots, queues make/break events and emits
// each one as an uppercase ASCII hex string with an optional terminator.
module ps2_event_reporter
    import ps2_pkg::*;
#(
    parameter int DEPTH           = 4,
    parameter int SUPPRESS_REPEAT = 1,
    parameter int REPORT_BREAK    = 1,
    parameter int TERM_MODE       = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] keycode,
    input  logic        keycode_valid,
    output logic [7:0]  out_byte,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        overflow,
    output logic [7:0]  drop_cnt,
    output logic        busy
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_HEX   = 3'd2;
    localparam logic [2:0] S_TERM1 = 3'd3;
    localparam logic [2:0] S_TERM2 = 3'd4;

    logic [2:0]  state_q, state_d;
    ps2_entry_t  entry_q, entry_d;
    logic [15:0] sh_q, sh_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] last_code_q;
    logic        last_brk_q;
    logic        ovf_q, ovf_d;
    logic [7:0]  drop_cnt_q;

    logic        partial, is_break, is_ext;
    logic        drop_make, drop_brk, accept;
    logic [1:0]  kind;
    logic        fifo_full, fifo_empty, pop, xfer;
    ps2_entry_t  wentry, rentry;

    always_comb begin
        partial   = (keycode[7:0] == PFX_BREAK);
        is_break  = (keycode[15:8] == PFX_BREAK);
        is_ext    = (keycode[15:8] == PFX_EXT);
        kind      = is_break ? KIND_BREAK : (is_ext ? KIND_EXT : KIND_MAKE);
        drop_make = (SUPPRESS_REPEAT != 0) && !last_brk_q &&
                    (is_ext ? (keycode == last_code_q)
                            : (keycode[7:0] == last_code_q[7:0]));
        drop_brk  = (REPORT_BREAK == 0) || (keycode == last_code_q);
        accept    = keycode_valid && !partial &&
                    !(is_break ? drop_brk : drop_make);
        wentry    = '{kind: kind, code: keycode};
    end

    assign pop   = (state_q == S_IDLE) && !fifo_empty;
    assign ovf_d = accept && fifo_full && !pop;

    ps2_event_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .push_i  (accept),
        .wdata_i (wentry),
        .pop_i   (pop),
        .rdata_o (rentry),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign out_valid = (state_q == S_HEX) || (state_q == S_TERM1) ||
                       (state_q == S_TERM2);
    assign xfer      = out_valid && out_ready;
    assign busy      = !fifo_empty || (state_q != S_IDLE);
    assign overflow  = ovf_q;
    assign drop_cnt  = drop_cnt_q;

    always_comb begin
        out_byte = 8'h00;
        unique case (state_q)
            S_HEX:   out_byte = nib2ascii(sh_q[15:12]);
            S_TERM1: out_byte = (TERM_MODE == 1) ? ASCII_SP : ASCII_CR;
            S_TERM2: out_byte = ASCII_LF;
            default: out_byte = 8'h00;
        endcase
    end

    // The shifter is left-aligned so the next nibble is always sh_q[15:12].
    always_comb begin
        state_d = state_q;
        entry_d = entry_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (pop) begin
                    entry_d = rentry;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (entry_q.kind == KIND_MAKE) begin
                    sh_d  = {entry_q.code[7:0], 8'h00};
                    cnt_d = 3'd2;
                end else begin
                    sh_d  = entry_q.code;
                    cnt_d = 3'd4;
                end
                state_d = S_HEX;
            end
            S_HEX: begin
                if (xfer) begin
                    sh_d  = {sh_q[11:0], 4'h0};
                    cnt_d = cnt_q - 3'd1;
                    if (cnt_q == 3'd1) begin
                        state_d = (TERM_MODE != 0) ? S_TERM1 : S_IDLE;
                    end
                end
            end
            S_TERM1: begin
                if (xfer) state_d = (TERM_MODE == 2) ? S_TERM2 : S_IDLE;
            end
            S_TERM2: begin
                if (xfer) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            entry_q     <= '0;
            sh_q        <= '0;
            cnt_q       <= '0;
            last_code_q <= '0;
            last_brk_q  <= 1'b1;
            ovf_q       <= 1'b0;
            drop_cnt_q  <= '0;
        end else begin
            state_q <= state_d;
            entry_q <= entry_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
            if (accept) begin
                last_code_q <= keycode;
                last_brk_q  <= is_break;
            end
            if (ovf_d && (drop_cnt_q != 8'hFF)) begin
                drop_cnt_q <= drop_cnt_q + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_ps2_event_reporter.sv
// Scoreboard bench: instance 0 uses defaults (CR LF, repeat filter),
// instance 1 uses SUPPRESS_REPEAT=0 and TERM_MODE=1 on the same stimulus.
module tb_ps2_event_reporter;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [15:0]     kc = 16'h0000;
    logic            kv = 1'b0;
    logic            ordy = 1'b1;
    logic [1:0][7:0] ob;
    logic [1:0][7:0] dc;
    logic [1:0]      ov;
    logic [1:0]      ovf;
    logic [1:0]      bsy;

    logic [7:0] exp_q [2][$];
    int         n_chk = 0;
    int         n_fail = 0;
    int         ovf_cnt [2];
    logic       stall [2];
    logic [7:0] held [2];

    always #5 clk = ~clk;

    ps2_event_reporter #(
        .DEPTH(4), .SUPPRESS_REPEAT(1), .REPORT_BREAK(1), .TERM_MODE(2)
    ) u_main (
        .clk(clk), .rst(rst), .keycode(kc), .keycode_valid(kv),
        .out_byte(ob[0]), .out_valid(ov[0]), .out_ready(ordy),
        .overflow(ovf[0]), .drop_cnt(dc[0]), .busy(bsy[0])
    );

    ps2_event_reporter #(
        .DEPTH(4), .SUPPRESS_REPEAT(0), .REPORT_BREAK(1), .TERM_MODE(1)
    ) u_alt (
        .clk(clk), .rst(rst), .keycode(kc), .keycode_valid(kv),
        .out_byte(ob[1]), .out_valid(ov[1]), .out_ready(ordy),
        .overflow(ovf[1]), .drop_cnt(dc[1]), .busy(bsy[1])
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Instance 0 ends each event with CR LF, instance 1 with a space.
    task automatic exp_one(input int i, input string hex);
        for (int k = 0; k < hex.len(); k++) exp_q[i].push_back(hex[k]);
        if (i == 0) begin
            exp_q[0].push_back(8'h0D);
            exp_q[0].push_back(8'h0A);
        end else begin
            exp_q[1].push_back(8'h20);
        end
    endtask

    task automatic exp_both(input string hex);
        exp_one(0, hex);
        exp_one(1, hex);
    endtask

    task automatic pulse(input logic [15:0] code);
        @(posedge clk); #1;
        kc = code;
        kv = 1'b1;
        @(posedge clk); #1;
        kv = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic wait_idle(input string nm);
        bit done = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            @(posedge clk); #1;
            done = (bsy == 2'b00) && (exp_q[0].size() == 0) &&
                   (exp_q[1].size() == 0);
        end
        n_chk++;
        if (!done) begin
            n_fail++;
            $display("FAIL %s: drain timeout busy=%b left=%0d/%0d", nm, bsy,
                     exp_q[0].size(), exp_q[1].size());
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            stall[0] = 1'b0;
            stall[1] = 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (ovf[i]) ovf_cnt[i]++;
                if (stall[i]) begin
                    chk($sformatf("hold_valid%0d", i), 32'(ov[i]), 32'd1);
                    chk($sformatf("hold_byte%0d", i), 32'(ob[i]), 32'(held[i]));
                end
                if (ov[i] && ordy) begin
                    if (exp_q[i].size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL out%0d: got %h expected nothing",
                                 i, ob[i]);
                    end else begin
                        chk($sformatf("out%0d", i), 32'(ob[i]),
                            32'(exp_q[i].pop_front()));
                    end
                end
                stall[i] = ov[i] && !ordy;
                held[i]  = ob[i];
            end
        end
    end

    initial begin
        bit found;
        ovf_cnt[0] = 0;
        ovf_cnt[1] = 0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_byte%0d", i), 32'(ob[i]), 32'd0);
            chk($sformatf("rst_valid%0d", i), 32'(ov[i]), 32'd0);
            chk($sformatf("rst_ovf%0d", i), 32'(ovf[i]), 32'd0);
            chk($sformatf("rst_drop%0d", i), 32'(dc[i]), 32'd0);
            chk($sformatf("rst_busy%0d", i), 32'(bsy[i]), 32'd0);
        end
        rst = 1'b1;

        // Single make: first byte three cycles after the pulse.
        exp_both("1C");
        pulse(16'h001C);
        chk("lat_n0_valid", 32'(ov[0]), 32'd0);
        chk("lat_n0_busy", 32'(bsy[0]), 32'd1);
        @(posedge clk); #1;
        chk("lat_n1_valid", 32'(ov[0]), 32'd0);
        @(posedge clk); #1;
        chk("lat_n2_valid", 32'(ov[0]), 32'd1);
        chk("lat_n2_byte", 32'(ob[0]), 32'h31);
        chk("lat_n2_valid_alt", 32'(ov[1]), 32'd1);
        wait_idle("single");

        // Typematic repeats then break.
        do_reset();
        exp_both("1C");
        exp_one(1, "1C");
        exp_one(1, "1C");
        exp_both("F01C");
        pulse(16'h001C);
        pulse(16'h001C);
        pulse(16'h001C);
        pulse(16'hF01C);
        wait_idle("typematic");

        // Extended make, partial code, extended break.
        exp_both("E075");
        exp_both("F075");
        pulse(16'hE075);
        pulse(16'h1CF0);
        pulse(16'hF075);
        wait_idle("extended");

        // Stalled sink: one event sits in the serialiser, four in the FIFO.
        @(posedge clk); #1;
        ordy = 1'b0;
        ovf_cnt[0] = 0;
        ovf_cnt[1] = 0;
        exp_both("15");
        exp_both("16");
        exp_both("21");
        exp_both("22");
        exp_both("23");
        pulse(16'h0015);
        pulse(16'h0016);
        pulse(16'h0021);
        pulse(16'h0022);
        pulse(16'h0023);
        pulse(16'h0024);
        pulse(16'h0025);
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("ovf_pulses%0d", i), 32'(ovf_cnt[i]), 32'd2);
            chk($sformatf("drop_cnt%0d", i), 32'(dc[i]), 32'd2);
            chk($sformatf("stall_busy%0d", i), 32'(bsy[i]), 32'd1);
        end
        ordy = 1'b1;
        wait_idle("overflow");

        // Sink toggling ready every cycle.
        exp_both("E075");
        pulse(16'hE075);
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #1;
            ordy = ~ordy;
        end
        ordy = 1'b1;
        wait_idle("toggle");

        // Reset while the third nibble of F01C is on the output.
        exp_both("F01C");
        pulse(16'hF01C);
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(posedge clk); #1;
            found = ov[0] && (ob[0] == 8'h31);
        end
        chk("mid_found", 32'(found), 32'd1);
        rst = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("mid_valid%0d", i), 32'(ov[i]), 32'd0);
            chk($sformatf("mid_drop%0d", i), 32'(dc[i]), 32'd0);
            chk($sformatf("mid_busy%0d", i), 32'(bsy[i]), 32'd0);
            exp_q[i].delete();
        end
        @(posedge clk); #1;
        rst = 1'b1;
        exp_both("29");
        pulse(16'h0029);
        wait_idle("after_reset");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
